// File: rtl/tft_pkg.sv
// rtl/tft_pkg.sv - shared types and constants for the TFT init sequencer and SPI word transmitter
package tft_pkg;

    localparam int ROM_ADDR_W = 7;
    localparam int ROM_DATA_W = 17;
    localparam int RS_BIT     = 16;
    localparam int WORD_W     = 16;
    localparam int MS_W       = 16;

    localparam int DEF_ROM_LAST = 89;
    localparam int DEF_DLY0_IDX = 10;
    localparam int DEF_DLY0_MS  = 40;
    localparam int DEF_DLY1_IDX = 20;
    localparam int DEF_DLY1_MS  = 10;
    localparam int DEF_DLY2_IDX = 22;
    localparam int DEF_DLY2_MS  = 50;
    localparam int DEF_DLY3_IDX = 86;
    localparam int DEF_DLY3_MS  = 50;
    localparam int DEF_HWRST_MS = 10;

    typedef enum logic [2:0] {
        IDLE,
        HWRST,
        HWWAIT,
        FETCH,
        SEND,
        DELAY,
        DONE
    } seq_state_t;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_LEAD,
        TX_HIGH,
        TX_LOW,
        TX_TRAIL,
        TX_GAP
    } tx_state_t;

endpackage

// File: rtl/tft_spi_word_tx.sv
// rtl/tft_spi_word_tx.sv - mode-0 SPI transmitter for one 16-bit word plus RS, MSB first
module tft_spi_word_tx
    import tft_pkg::*;
#(
    parameter int SPI_DIV = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [WORD_W-1:0] word,
    input  logic              rs,
    output logic              sck,
    output logic              mosi,
    output logic              cs_n,
    output logic              rs_out,
    output logic              done
);

    localparam int CW = $clog2(SPI_DIV);

    tx_state_t   st, st_n;
    logic [CW-1:0] cnt;
    logic [3:0]  bitcnt;
    logic [14:0] sh;
    logic        pend;
    logic        half_end;
    logic        can_load;

    assign half_end = (cnt == CW'(SPI_DIV - 1));
    assign can_load = load && ((st == TX_IDLE) || (st == TX_GAP));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st <= TX_IDLE;
        end else begin
            st <= st_n;
        end
    end

    // A load arriving during the CS-high gap is held until the gap has elapsed.
    always_comb begin
        st_n = st;
        case (st)
            TX_IDLE:  if (load) st_n = TX_LEAD;
            TX_LEAD:  if (half_end) st_n = TX_HIGH;
            TX_HIGH:  if (half_end) st_n = (bitcnt == 4'd15) ? TX_TRAIL : TX_LOW;
            TX_LOW:   if (half_end) st_n = TX_HIGH;
            TX_TRAIL: if (half_end) st_n = TX_GAP;
            TX_GAP:   if (half_end) st_n = (pend || load) ? TX_LEAD : TX_IDLE;
            default:  st_n = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt    <= '0;
            bitcnt <= '0;
            sh     <= '0;
            pend   <= 1'b0;
            sck    <= 1'b0;
            mosi   <= 1'b0;
            cs_n   <= 1'b1;
            rs_out <= 1'b0;
            done   <= 1'b0;
        end else begin
            done <= (st == TX_GAP) && (cnt == '0);

            if ((st_n != st) || (st == TX_IDLE)) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end

            if (can_load) begin
                sh     <= word[14:0];
                mosi   <= word[15];
                rs_out <= rs;
            end

            if (st_n == TX_LEAD) begin
                pend <= 1'b0;
            end else if (load && (st == TX_GAP)) begin
                pend <= 1'b1;
            end

            if (st_n == TX_LEAD) begin
                cs_n   <= 1'b0;
                bitcnt <= '0;
            end

            if (((st == TX_LEAD) || (st == TX_LOW)) && half_end) begin
                sck <= 1'b1;
            end

            // Next bit is presented on the same edge that drops SCK.
            if ((st == TX_HIGH) && half_end) begin
                sck <= 1'b0;
                if (bitcnt != 4'd15) begin
                    mosi   <= sh[14];
                    sh     <= {sh[13:0], 1'b0};
                    bitcnt <= bitcnt + 4'd1;
                end
            end

            if ((st == TX_TRAIL) && half_end) begin
                cs_n <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/tft_init_sequencer.sv
// rtl/tft_init_sequencer.sv - TFT init ROM walker with ms delays; optional panel reset via TFT_HW_RESET_EN
module tft_init_sequencer
    import tft_pkg::*;
#(
    parameter int CYCLES_PER_MS = 100000,
    parameter int SPI_DIV       = 4,
    parameter int ROM_LAST      = DEF_ROM_LAST,
    parameter int DLY0_IDX      = DEF_DLY0_IDX,
    parameter int DLY0_MS       = DEF_DLY0_MS,
    parameter int DLY1_IDX      = DEF_DLY1_IDX,
    parameter int DLY1_MS       = DEF_DLY1_MS,
    parameter int DLY2_IDX      = DEF_DLY2_IDX,
    parameter int DLY2_MS       = DEF_DLY2_MS,
    parameter int DLY3_IDX      = DEF_DLY3_IDX,
    parameter int DLY3_MS       = DEF_DLY3_MS,
    parameter int HWRST_MS      = DEF_HWRST_MS
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic [ROM_ADDR_W-1:0] rom_addr,
    input  logic [ROM_DATA_W-1:0] rom_data,
    output logic                  spi_sck,
    output logic                  spi_mosi,
    output logic                  spi_cs_n,
    output logic                  spi_rs,
    output logic                  tft_rst_n,
    output logic                  busy,
    output logic                  done
);

    localparam int PW = $clog2(CYCLES_PER_MS + 1);

    seq_state_t      state, state_n;
    logic [MS_W-1:0] ms_cnt, ms_val, dly_ms;
    logic [PW-1:0]   pre_cnt;
    logic            pre_init, ms_load, addr_clr, addr_inc;
    logic            tx_load, tx_done, dly_hit;
    logic            is_last, ms_tick, ms_expire, counting;

    assign is_last   = (rom_addr == ROM_ADDR_W'(ROM_LAST));
    assign ms_tick   = (pre_cnt == PW'(CYCLES_PER_MS - 1));
    assign ms_expire = (ms_cnt == '0) || (ms_tick && (ms_cnt == MS_W'(1)));
    assign counting  = (state == DELAY) || (state == HWRST) || (state == HWWAIT);
    assign busy      = (state != IDLE) && (state != DONE);
    assign done      = (state == DONE);

    always_comb begin
        dly_hit = 1'b1;
        dly_ms  = '0;
        if (rom_addr == ROM_ADDR_W'(DLY0_IDX))      dly_ms = MS_W'(DLY0_MS);
        else if (rom_addr == ROM_ADDR_W'(DLY1_IDX)) dly_ms = MS_W'(DLY1_MS);
        else if (rom_addr == ROM_ADDR_W'(DLY2_IDX)) dly_ms = MS_W'(DLY2_MS);
        else if (rom_addr == ROM_ADDR_W'(DLY3_IDX)) dly_ms = MS_W'(DLY3_MS);
        else                                        dly_hit = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n  = state;
        tx_load  = 1'b0;
        addr_clr = 1'b0;
        addr_inc = 1'b0;
        ms_load  = 1'b0;
        ms_val   = dly_ms;
        pre_init = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    addr_clr = 1'b1;
                    ms_load  = 1'b1;
                    ms_val   = MS_W'(HWRST_MS);
`ifdef TFT_HW_RESET_EN
                    state_n  = HWRST;
`else
                    state_n  = FETCH;
`endif
                end
            end
`ifdef TFT_HW_RESET_EN
            HWRST: begin
                if (ms_expire) begin
                    ms_load = 1'b1;
                    ms_val  = MS_W'(HWRST_MS);
                    state_n = HWWAIT;
                end
            end
            HWWAIT: if (ms_expire) state_n = FETCH;
`endif
            FETCH: begin
                tx_load = 1'b1;
                state_n = SEND;
            end
            // The cycle that sees tx_done counts as the first delay cycle.
            SEND: begin
                if (tx_done) begin
                    if (dly_hit) begin
                        ms_load  = 1'b1;
                        pre_init = 1'b1;
                        state_n  = DELAY;
                    end else if (is_last) begin
                        state_n = DONE;
                    end else begin
                        addr_inc = 1'b1;
                        state_n  = FETCH;
                    end
                end
            end
            DELAY: begin
                if (ms_expire) begin
                    if (is_last) begin
                        state_n = DONE;
                    end else begin
                        addr_inc = 1'b1;
                        state_n  = FETCH;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rom_addr <= ROM_ADDR_W'(1);
            ms_cnt   <= '0;
            pre_cnt  <= '0;
        end else begin
            if (addr_clr) begin
                rom_addr <= ROM_ADDR_W'(1);
            end else if (addr_inc) begin
                rom_addr <= rom_addr + 1'b1;
            end

            if (ms_load) begin
                ms_cnt  <= ms_val;
                pre_cnt <= PW'(pre_init);
            end else if (counting) begin
                if (ms_tick) begin
                    pre_cnt <= '0;
                    if (ms_cnt != '0) ms_cnt <= ms_cnt - 1'b1;
                end else begin
                    pre_cnt <= pre_cnt + 1'b1;
                end
            end
        end
    end

`ifdef TFT_HW_RESET_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tft_rst_n <= 1'b1;
        end else begin
            tft_rst_n <= (state_n != HWRST);
        end
    end
`else
    assign tft_rst_n = 1'b1;
`endif

    // ROM data goes straight into the transmitter's shift/RS registers during FETCH.
    tft_spi_word_tx #(
        .SPI_DIV (SPI_DIV)
    ) u_tx (
        .clk    (clk),
        .rst    (rst),
        .load   (tx_load),
        .word   (rom_data[WORD_W-1:0]),
        .rs     (rom_data[RS_BIT]),
        .sck    (spi_sck),
        .mosi   (spi_mosi),
        .cs_n   (spi_cs_n),
        .rs_out (spi_rs),
        .done   (tx_done)
    );

endmodule

// File: doc/tft_init_sequencer.md
Name: tft_init_sequencer

Overview:
- Walks the TFT initialization command ROM from address 1 to the last entry. Address 0 is a dummy entry and is never sent.
- Each 17-bit entry is a 1-bit RS flag plus a 16-bit word. The block serializes each word MSB-first on a mode-0 SPI link and drives RS alongside it.
- Inserts the power-on millisecond delays the panel needs, then asserts done so the pixel-streaming logic can take over the SPI bus.

Parameters:
- CYCLES_PER_MS, 100000, clk cycles per millisecond; the delay prescaler terminal count.
- SPI_DIV, 4, clk cycles per SCK half period; must be >= 2.
- ROM_LAST, 89, last ROM address sent; this entry is the GRAM data register index.
- DLY0_IDX / DLY0_MS, 10 / 40, after sending this address, wait this many ms.
- DLY1_IDX / DLY1_MS, 20 / 10, same meaning.
- DLY2_IDX / DLY2_MS, 22 / 50, same meaning.
- DLY3_IDX / DLY3_MS, 86 / 50, same meaning.
- HWRST_MS, 10, TFT reset low time and post-reset wait; used only with TFT_HW_RESET_EN.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle pulse that begins the sequence; ignored while busy.
- rom_addr  out  7  address to the combinational init ROM.
- rom_data  in  17  ROM entry; [16] is RS, [15:0] is the word.
- spi_sck  out  1  SPI clock; idles low.
- spi_mosi  out  1  serial data, MSB first.
- spi_cs_n  out  1  chip select, active low.
- spi_rs  out  1  register-select line; valid for the whole time CS is low.
- tft_rst_n  out  1  panel reset; constant 1 unless TFT_HW_RESET_EN is defined.
- busy  out  1  high from the cycle after start until done.
- done  out  1  sticky high after the last word; cleared by the next start.

Behaviour:
- Reset values: rom_addr=1, spi_sck=0, spi_mosi=0, spi_cs_n=1, spi_rs=0, tft_rst_n=1, busy=0, done=0. FSM state is IDLE.
- FSM states: IDLE, HWRST, HWWAIT, FETCH, SEND, DELAY, DONE.
- IDLE:
  - start goes to HWRST if the macro is defined, otherwise to FETCH.
  - On entry, rom_addr is set to 1.
- FETCH (1 cycle):
  - Register rom_data into word/RS holding registers.
  - Assert the serializer load strobe.
  - Go to SEND.
- SEND: wait for the serializer's done pulse, then:
  - if rom_addr equals any DLYn_IDX, load the ms counter with DLYn_MS and go to DELAY;
  - else if rom_addr == ROM_LAST, go to DONE;
  - else increment rom_addr and go to FETCH.
- DELAY:
  - The prescaler counts 0..CYCLES_PER_MS-1. Each wrap decrements the ms counter.
  - When the ms counter reaches 0: if rom_addr == ROM_LAST, go to DONE; otherwise increment rom_addr and go to FETCH.
  - Total delay is DLYn_MS*CYCLES_PER_MS cycles, within ±1 cycle.
- DONE: done=1, busy=0. start goes back through the IDLE entry path, which clears done and resets rom_addr to 1.
- Serializer timing, per word:
  - CS falls, and RS and MOSI bit 15 are set up, one half period before the first SCK rising edge.
  - 16 SCK pulses, each SPI_DIV high and SPI_DIV low.
  - MOSI changes only while SCK is low.
  - CS rises SPI_DIV cycles after the last falling edge.
  - CS then stays high at least SPI_DIV cycles before the next word.
  - Done pulses 1 cycle after CS rises.
- Word time is therefore 34*SPI_DIV clk cycles, ±1 cycle of load overhead.
- start while busy is ignored. rst mid-word forces CS high and SCK low immediately; the partial word is abandoned.
- rom_addr changes only in FETCH/SEND transitions and is stable for at least 1 cycle before it is sampled.

Optional Feature:
- Macro: TFT_HW_RESET_EN.
- Defined:
  - HWRST drives tft_rst_n=0 for HWRST_MS ms.
  - HWWAIT releases tft_rst_n=1 and waits HWRST_MS ms, then goes to FETCH.
  - Both states reuse the ms counter and prescaler.
- Undefined: the HWRST/HWWAIT states and their logic are absent, tft_rst_n is tied to 1, and start goes directly to FETCH.

Decomposition:
- Shared package tft_pkg:
  - FSM state enum;
  - ROM_ADDR_W=7 and ROM_DATA_W=17;
  - RS bit index 16;
  - default delay index and ms constants.
- One sub-module, tft_spi_word_tx:
  - inputs: load, word[15:0], rs;
  - outputs: sck, mosi, cs_n, rs_out, done.
- The same sub-module is reusable by the pixel streamer.

Test Plan:
- Bench settings: CYCLES_PER_MS=10, SPI_DIV=2, ROM model returns the production table.
- Sequence decode: pulse start, decode SPI on SCK rising edges.
  - First word is 0x0010 with RS=0; second is 0x0000 with RS=1.
  - Exactly 89 words, and the last is 0x0022 with RS=0.
  - done rises and busy falls in the same cycle.
- Delays:
  - Gap between CS rising after word 10 and the next CS falling is 400 cycles ±2.
  - Gap after word 22 is 500 cycles ±2.
  - Gap after any non-delay word is between 2 and 4 cycles.
- SPI timing:
  - SCK period is 4 cycles.
  - MOSI stable across every rising edge.
  - spi_rs constant while CS is low.
  - 16 rising edges per CS-low window.
- Reset and start handling:
  - Assert rst during word 30: within 1 cycle CS=1, SCK=0, busy=0, rom_addr=1.
  - A new start replays from word 0x0010.
  - A start pulse while busy has no effect on the word count; in DONE, start clears done and reruns all 89 words.
- With TFT_HW_RESET_EN defined:
  - tft_rst_n is low for 100 cycles after start;
  - the first CS fall is 100 cycles after tft_rst_n rises, ±3.
